reversible_inverse_unit: RTL
============================

# reversible_inverse_unit

Recovers the original operand triple (A, B, C) from the 32-bit outputs (P, Q, R) of a bank of reversible gates: Fredkin, Peres or Feynman. The block sits downstream of the reversible arithmetic/logic operations datapath and runs its inverse direction. It processes each word bit-serially in LANE_W-bit slices, which bounds the reversible-gate count per cycle. Words enter and leave through valid/ready handshakes.

## Interface
- WIDTH, 32, operand width; must be a multiple of LANE_W
- LANE_W, 8, bits inverted per cycle; N = WIDTH/LANE_W cycles per word
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_gate  in  2  0 = Fredkin, 1 = Peres, 2 = Feynman, 3 = reserved
- in_p, in_q, in_r  in  WIDTH each  reversible-gate outputs to invert
- out_valid  out  1  recovered word valid
- out_ready  in  1  downstream accepts the word
- out_a, out_b, out_c  out  WIDTH each  recovered operands
- out_err  out  1  word used the reserved gate code
- words_done  out  16  count of delivered words, saturating

## Operation
- Inverse functions, bitwise:
  - Fredkin (self-inverse): A = P; B = (~P&Q)|(P&R); C = (~P&R)|(P&Q).
  - Peres: A = P; B = P^Q; C = R^(P&(P^Q)).
  - Feynman: A = P; B = P^Q; C = R.
  - Reserved (3): A = B = C = 0; out_err = 1.
- FSM states:
  - IDLE: in_ready = 1. When in_valid & in_ready, latch in_p/q/r/gate, set lane index k = 0, go to RUN.
  - RUN: each cycle, invert slice [k*LANE_W +: LANE_W] into the working registers, then k++. After slice N-1, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE and increment words_done (holds at 16'hFFFF).
- Slices are processed LSB first.
- in_ready = (state == IDLE). Inputs are ignored outside IDLE.
- out_a/b/c/err update atomically on the RUN→DONE transition. They hold their values until the next RUN→DONE transition, so they never show partial results.
- out_valid and its data stay stable while out_ready is low; backpressure is unbounded.

## Timing
- Reset (async assert, sync release): state = IDLE, in_ready = 1, out_valid = 0, out_a/b/c = 0, out_err = 0, words_done = 0, k = 0.
- Accept at edge t0. RUN occupies cycles t0..t0+N-1. out_valid rises after edge t0+N, so latency = N cycles (4 at defaults).
- With out_ready held high, the output handshake occurs at edge t0+N+1. in_ready is high again after that edge, and the next accept can occur at edge t0+N+2. Throughput is one word per N+2 cycles.
- The block does not re-accept a word in the same cycle as the output handshake.
- rst_n low mid-RUN or mid-DONE: the word in flight is discarded, no output handshake occurs, and words_done does not change except that it clears to 0.
- in_gate is sampled only at acceptance. Changes to in_gate during RUN have no effect.

## Test plan
- Peres: in_p = AAAAAAAA, in_q = FFFFFFFF, in_r = 00000001, gate = 1 -> out_valid 4 cycles after accept; A = AAAAAAAA, B = 55555555, C = 00000001, err = 0.
- Fredkin: in_p = FFFF0000, in_q = 9ABC5678, in_r = 1234DEF0, gate = 0 -> A = FFFF0000, B = 12345678, C = 9ABCDEF0.
- Feynman then reserved, back-to-back:
  - Word 1: in_p = FFFFFFFF, in_q = FFFFFFFF, in_r = 0, gate = 2 -> A = FFFFFFFF, B = 0, C = 0.
  - Word 2: gate = 3 -> A = B = C = 0, err = 1.
  - words_done = 2. Second accept occurs exactly 6 cycles after the first.
- Backpressure: hold out_ready low for 10 cycles in DONE -> out_valid and data stable, in_ready = 0, in_valid pulses ignored. words_done increments once when out_ready rises.
- Reset mid-RUN: assert rst_n low at k = 2 -> out_valid = 0, outputs = 0, in_ready = 1. A subsequent Peres word completes normally.

Source files
------------

// File: rtl/reversible_inverse_unit.sv
// Inverts Fredkin / Peres / Feynman gate outputs back to (A, B, C), one LANE_W slice per cycle.
// Results are published all at once when the last slice finishes, then held until the next word completes.
module reversible_inverse_unit #(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_gate,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
  input  logic [WIDTH-1:0] in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic             out_err,
  output logic [15:0]      words_done
);

  // state | meaning
  // IDLE  | waiting for a word, in_ready high
  // RUN   | inverting slice k (LSB first)
  // DONE  | holding result, out_valid high
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N  = WIDTH / LANE_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t            state, state_nxt;
  logic [KW-1:0]     k;
  logic [1:0]        gate_q;
  logic [WIDTH-1:0]  p_q, q_q, r_q;
  logic [WIDTH-1:0]  work_a, work_b, work_c;
  logic [WIDTH-1:0]  work_a_nxt, work_b_nxt, work_c_nxt;
  logic [LANE_W-1:0] sp, sq, sr, sa, sb, sc;
  logic              last;
  int                base;

  assign last = (k == KW'(N - 1));

  always_comb begin
    base = int'(k) * LANE_W;
    sp   = p_q[base +: LANE_W];
    sq   = q_q[base +: LANE_W];
    sr   = r_q[base +: LANE_W];
    sa   = sp;
    sb   = '0;
    sc   = '0;
    case (gate_q)
      2'd0: begin
        sb = (~sp & sq) | (sp & sr);
        sc = (~sp & sr) | (sp & sq);
      end
      2'd1: begin
        sb = sp ^ sq;
        sc = sr ^ (sp & (sp ^ sq));
      end
      2'd2: begin
        sb = sp ^ sq;
        sc = sr;
      end
      default: sa = '0;
    endcase
    work_a_nxt = work_a;
    work_b_nxt = work_b;
    work_c_nxt = work_c;
    work_a_nxt[base +: LANE_W] = sa;
    work_b_nxt[base +: LANE_W] = sb;
    work_c_nxt[base +: LANE_W] = sc;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      gate_q     <= '0;
      p_q        <= '0;
      q_q        <= '0;
      r_q        <= '0;
      work_a     <= '0;
      work_b     <= '0;
      work_c     <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_c      <= '0;
      out_err    <= 1'b0;
      words_done <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          p_q    <= in_p;
          q_q    <= in_q;
          r_q    <= in_r;
          gate_q <= in_gate;
          k      <= '0;
        end
        RUN: begin
          work_a <= work_a_nxt;
          work_b <= work_b_nxt;
          work_c <= work_c_nxt;
          k      <= last ? '0 : k + 1'b1;
          if (last) begin
            out_a   <= work_a_nxt;
            out_b   <= work_b_nxt;
            out_c   <= work_c_nxt;
            out_err <= (gate_q == 2'd3);
          end
        end
        DONE: if (out_ready && words_done != 16'hFFFF) words_done <= words_done + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
